mux4_reg: RTL and testbench



---
 rtl/mux4_reg.sv | 39 +++
 tb/tb_mux4_reg.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mux4_reg.sv
// Registered 4:1 selector: {s1,s2} picks a/b/c/d, and the choice is captured into y on every rising edge.
// Serves as the leaf cell of wider selector trees. Each cascade level adds one clock of latency.
module mux4_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s2
);

    logic [WIDTH-1:0] sel_data;

    // Only the addressed input reaches sel_data, so a floating c/d on a
    // second-level cell with s1=0 never leaks into y.
    always_comb begin
        sel_data = a;
        case ({s1, s2})
            2'b00:   sel_data = a;
            2'b01:   sel_data = b;
            2'b10:   sel_data = c;
            default: sel_data = d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else begin
            y <= sel_data;
        end
    end

endmodule

// File: tb/tb_mux4_reg.sv
// Self-checking bench for mux4_reg: a vector table, a random model check, single-bit corner cases
// and a two-level 8:1 cascade.
module tb_mux4_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 8-bit cell
    logic [7:0] a8, b8, c8, d8, y8;
    logic       s1_8, s2_8;
    mux4_reg #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .y(y8), .a(a8), .b(b8), .c(c8), .d(d8),
        .s1(s1_8), .s2(s2_8)
    );

    // 1-bit cell
    logic a1, b1, c1, d1, y1, s1_1, s2_1;
    mux4_reg #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .y(y1), .a(a1), .b(b1), .c(c1), .d(d1),
        .s1(s1_1), .s2(s2_1)
    );

    // Two-level 8:1 tree
    logic [7:0] din;
    logic [2:0] cas_k;
    logic       s3_d;
    logic       y_lo, y_hi, y_cas;
    mux4_reg #(.WIDTH(1)) u_lo (
        .clk(clk), .rst(rst), .y(y_lo), .a(din[0]), .b(din[1]), .c(din[2]), .d(din[3]),
        .s1(cas_k[1]), .s2(cas_k[0])
    );
    mux4_reg #(.WIDTH(1)) u_hi (
        .clk(clk), .rst(rst), .y(y_hi), .a(din[4]), .b(din[5]), .c(din[6]), .d(din[7]),
        .s1(cas_k[1]), .s2(cas_k[0])
    );
    mux4_reg #(.WIDTH(1)) u_top (
        .clk(clk), .rst(rst), .y(y_cas), .a(y_lo), .b(y_hi), .c(1'bz), .d(1'bz),
        .s1(1'b0), .s2(s3_d)
    );
    always @(posedge clk) s3_d <= cas_k[2];

    typedef struct {
        logic       rst;
        logic [7:0] a, b, c, d;
        logic [1:0] sel;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic [7:0] va, vb, vc, vd,
                           input logic [1:0] sel, input logic [7:0] exp);
        vec_t v;
        v.rst = r; v.a = va; v.b = vb; v.c = vc; v.d = vd; v.sel = sel; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ref_in[4];
        logic [7:0] exp8;
        logic       rst_r;

        a8 = '0; b8 = '0; c8 = '0; d8 = '0; s1_8 = 1'b0; s2_8 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; d1 = 1'b0; s1_1 = 1'b0; s2_1 = 1'b0;
        din = '0; cas_k = '0;

        // reset, select sweep, data tracking, mid-stream reset
        add_vec(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b00, 8'h00);
        add_vec(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'b11, 8'h00);
        add_vec(1'b0, 8'h10, 8'h21, 8'h32, 8'h43, 2'b00, 8'h10);
        add_vec(1'b0, 8'h10, 8'h21, 8'h32, 8'h43, 2'b01, 8'h21);
        add_vec(1'b0, 8'h10, 8'h21, 8'h32, 8'h43, 2'b10, 8'h32);
        add_vec(1'b0, 8'h10, 8'h21, 8'h32, 8'h43, 2'b11, 8'h43);
        add_vec(1'b0, 8'h00, 8'h01, 8'h00, 8'h01, 2'b00, 8'h00);
        add_vec(1'b0, 8'h00, 8'h01, 8'h00, 8'h01, 2'b01, 8'h01);
        add_vec(1'b0, 8'h00, 8'h01, 8'h00, 8'h01, 2'b10, 8'h00);
        add_vec(1'b0, 8'h00, 8'h01, 8'h00, 8'h01, 2'b11, 8'h01);
        add_vec(1'b0, 8'h11, 8'h55, 8'h33, 8'h77, 2'b01, 8'h55);
        add_vec(1'b0, 8'h11, 8'hAA, 8'hCC, 8'h77, 2'b01, 8'hAA);
        add_vec(1'b0, 8'hEE, 8'h55, 8'hCC, 8'h88, 2'b01, 8'h55);
        add_vec(1'b0, 8'hEE, 8'hAA, 8'h33, 8'h88, 2'b01, 8'hAA);
        add_vec(1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 2'b00, 8'hA5);
        add_vec(1'b1, 8'hA5, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00);
        add_vec(1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 2'b00, 8'hA5);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            a8 = vecs[i].a; b8 = vecs[i].b; c8 = vecs[i].c; d8 = vecs[i].d;
            {s1_8, s2_8} = vecs[i].sel;
            step();
            chk($sformatf("vec%0d", i), y8, vecs[i].exp);
        end

        // Random stimulus compared against a lookup-based model
        for (int unsigned n = 0; n < 200; n++) begin
            rst_r = ($urandom_range(15) == 0);
            for (int unsigned k = 0; k < 4; k++) ref_in[k] = 8'($urandom);
            rst = rst_r;
            a8 = ref_in[0]; b8 = ref_in[1]; c8 = ref_in[2]; d8 = ref_in[3];
            s1_8 = 1'($urandom); s2_8 = 1'($urandom);
            exp8 = rst_r ? 8'h00 : ref_in[2 * int'(s1_8) + int'(s2_8)];
            step();
            chk($sformatf("rand%0d", n), y8, exp8);
        end

        // 1-bit reset: held for two edges, then release
        rst = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; d1 = 1'b1;
        step(); chk("w1_rst0", {7'b0, y1}, 8'h00);
        step(); chk("w1_rst1", {7'b0, y1}, 8'h00);
        rst = 1'b0;
        step(); chk("w1_release", {7'b0, y1}, 8'h01);

        // Unselected c/d floating must never reach y
        s1_1 = 1'b0; a1 = 1'b1; b1 = 1'b0; c1 = 1'bz; d1 = 1'bx;
        for (int unsigned n = 0; n < 6; n++) begin
            s2_1 = n[0];
            step();
            chk($sformatf("float%0d", n), {7'b0, y1}, n[0] ? 8'h00 : 8'h01);
        end

        // 8:1 cascade, all select codes, result two clocks later
        for (int unsigned k = 0; k < 8; k++) begin
            for (int unsigned r = 0; r < 2; r++) begin
                din = (r == 0) ? 8'(1 << k) : ~8'(1 << k);
                cas_k = 3'(k);
                step();
                step();
                chk($sformatf("cas_k%0d_r%0d", k, r), {7'b0, y_cas}, {7'b0, din[cas_k]});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
